// File: rtl/main_mem_axil.sv
`default_nettype none
// ============================================================================
// Module  : main_mem_axil
// Brief   : AXI4-Lite single-ported word memory with programmable latency.
// Revision: 1.0 - initial release
// ============================================================================
module main_mem_axil #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    MEM_WORDS     = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h0000_0000,
    parameter int                    READ_LATENCY  = 4,
    parameter int                    WRITE_LATENCY = 2
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int         c_idx_w   = $clog2(MEM_WORDS);
    localparam logic [3:0] c_rd_load = 4'(READ_LATENCY - 1);
    localparam logic [3:0] c_wr_load = 4'(WRITE_LATENCY - 1);
    localparam logic [1:0] c_okay    = 2'b00;
    localparam logic [1:0] c_slverr  = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_WAIT = 3'd2,
        WR_RESP = 3'd3,
        RD_WAIT = 3'd4,
        RD_RESP = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_live;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_bresp;
    logic [1:0]              r_rresp;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0]   w_offset;
    logic                    w_in_range;
    logic [c_idx_w-1:0]      w_index;
    logic                    w_commit;
    logic                    w_unused;

    // BASE_ADDR is aligned to the array span, so in range means no offset bits above the index
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_in_range = (w_offset >> (c_idx_w + 2)) == '0;
    assign w_index    = w_offset[c_idx_w+1:2];
    assign w_commit   = !s_axi_areset && (r_state == WR_DATA) && s_axi_wvalid && w_in_range;
    assign w_unused   = ^{s_axi_awprot, s_axi_arprot, w_offset[1:0]};

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        case (r_state)
            IDLE: begin
                s_axi_awready = r_live;
                s_axi_arready = r_live && !s_axi_awvalid;
                if (r_live && s_axi_awvalid) begin
                    w_next = WR_DATA;
                end else if (r_live && s_axi_arvalid) begin
                    w_next = RD_WAIT;
                end
            end
            WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    w_next = (WRITE_LATENCY == 1) ? WR_RESP : WR_WAIT;
                end
            end
            WR_WAIT: if (r_cnt == 4'd0) w_next = WR_RESP;
            WR_RESP: if (s_axi_bready) w_next = IDLE;
            RD_WAIT: if (r_cnt == 4'd0) w_next = RD_RESP;
            RD_RESP: if (s_axi_rready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_bresp <= c_okay;
            r_rresp <= c_okay;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_next == WR_DATA) begin
                        r_addr <= s_axi_awaddr;
                    end else if (w_next == RD_WAIT) begin
                        r_addr <= s_axi_araddr;
                        r_cnt  <= c_rd_load;
                    end
                end
                WR_DATA: begin
                    if (s_axi_wvalid) begin
                        r_cnt   <= c_wr_load;
                        r_bresp <= w_in_range ? c_okay : c_slverr;
                    end
                end
                WR_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                RD_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata <= w_in_range ? r_mem[w_index] : '0;
                        r_rresp <= w_in_range ? c_okay : c_slverr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset
    always_ff @(posedge s_axi_aclk) begin
        if (w_commit) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (s_axi_wstrb[b]) r_mem[w_index][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi_bvalid = (r_state == WR_RESP);
    assign s_axi_rvalid = (r_state == RD_RESP);
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rdata  = r_rdata;

endmodule
`default_nettype wire
